// File: rtl/service_1_time_keeper.sv
// service_1_time_keeper: consumer end of the service_1 time-set interface.
//   Captures a BCD HH:MM word on a legal load, keeps 24 h time with internal
//   seconds, and drives a 4-digit multiplexed active-low 7-segment display.
// Ports:
//   clk, reset (async, active-high)
//   load, num_in[15:0] {H1,H0,M1,M0}   : load request and BCD time word
//   setting, sel_in[3:0]               : setter active (pause + blink), digit under edit
//   time_out[15:0], sec_out[5:0]       : current BCD time, binary seconds
//   min_tick, valid, load_err          : minute pulse, time-loaded flag, rejected-load pulse
//   an[3:0], seg[6:0]                  : digit enables / segments {g,f,e,d,c,b,a}, active-low
// Optional feature: define LEADING_ZERO_BLANK_EN to blank a zero H1 digit in RUN/HOLD.
module service_1_time_keeper #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] num_in,
  input  logic        setting,
  input  logic [3:0]  sel_in,
  output logic [15:0] time_out,
  output logic [5:0]  sec_out,
  output logic        min_tick,
  output logic        valid,
  output logic        load_err,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, next_state;

  logic [TW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic [1:0]    dig;

  // Load legality: hours 00..23, minutes 00..59, all nibbles BCD.
  logic legal, load_ok, load_bad;
  assign legal = (num_in[15:12] <= 4'd2) && (num_in[11:8] <= 4'd9) &&
                 !((num_in[15:12] == 4'd2) && (num_in[11:8] > 4'd3)) &&
                 (num_in[7:4] <= 4'd5) && (num_in[3:0] <= 4'd9);
  assign load_ok  = load && legal;
  assign load_bad = load && !legal;

  logic tick;
  assign tick = (state == RUN) && (presc == TICK_LAST);

  // Next-state logic; a legal load overrides the normal transitions and
  // picks RUN or HOLD from the setter level seen in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      RUN:     if (setting) next_state = HOLD;
      HOLD:    if (!setting) next_state = RUN;
      default: next_state = IDLE;
    endcase
    if (load_ok) next_state = setting ? HOLD : RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // BCD minute increment with 23:59 -> 00:00 wrap.
  logic [15:0] time_inc;
  always_comb begin
    time_inc = time_out;
    if (time_out == 16'h2359) begin
      time_inc = 16'h0000;
    end else if (time_out[3:0] != 4'd9) begin
      time_inc[3:0] = time_out[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_out[7:4] != 4'd5) begin
        time_inc[7:4] = time_out[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_out[11:8] != 4'd9) begin
          time_inc[11:8] = time_out[11:8] + 4'd1;
        end else begin
          time_inc[11:8]  = 4'd0;
          time_inc[15:12] = time_out[15:12] + 4'd1;
        end
      end
    end
  end

  // Timekeeping datapath. A load takes priority over a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_out <= 16'h0000;
      sec_out  <= 6'd0;
      presc    <= '0;
      min_tick <= 1'b0;
      valid    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      load_err <= load_bad;
      if (load_ok) begin
        time_out <= num_in;
        sec_out  <= 6'd0;
        presc    <= '0;
        valid    <= 1'b1;
      end else if (state == RUN) begin
        if (tick) begin
          presc <= '0;
          if (sec_out == 6'd59) begin
            sec_out  <= 6'd0;
            time_out <= time_inc;
            min_tick <= 1'b1;
          end else begin
            sec_out <= sec_out + 6'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = SEG_DASH;
    endcase
  endfunction

  logic [3:0] cur_nib;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  always_comb begin
    case (dig)
      2'd0:    cur_nib = time_out[3:0];
      2'd1:    cur_nib = time_out[7:4];
      2'd2:    cur_nib = time_out[11:8];
      default: cur_nib = time_out[15:12];
    endcase
    an_next  = ~(4'b0001 << dig);
    seg_next = SEG_DASH;
    if (state != IDLE) begin
      seg_next = glyph(cur_nib);
`ifdef LEADING_ZERO_BLANK_EN
      if ((dig == 2'd3) && (cur_nib == 4'd0)) seg_next = SEG_BLANK;
`endif
      if ((state == HOLD) && blink_ph && sel_in[dig]) seg_next = SEG_BLANK;
    end
  end

  // Scan and blink counters run freely; an/seg are registered together so
  // the enabled digit and its segments always change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      dig       <= 2'd0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      an        <= 4'b1110;
      seg       <= SEG_DASH;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
